// File: rtl/vproc_mem_responder_pkg.sv
// Shared types and helpers for the VProc memory responder: FSM encoding,
// out-of-window read value and the address-window decode.
package vproc_mem_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } resp_state_t;

    localparam logic [31:0] OOR_RDATA = 32'h0000_0000;

    // Window test: the bits above the RAM index must match the base.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int          abits);
        return (addr >> abits) == (base >> abits);
    endfunction

endpackage

// File: rtl/vproc_resp_ram.sv
// Single-port 32-bit RAM, 2^ADDR_BITS words; write-enable, registered read.
// One-cycle read latency, no backpressure; contents are not reset.
module vproc_resp_ram #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o
);

    logic [31:0] mem_q [2**ADDR_BITS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/vproc_mem_responder.sv
// VProc bus target: RAM-backed single/burst accesses with parameterised wait states.
// Ack pulses one cycle, W edges after the request edge; requests are level-held until acked.
module vproc_mem_responder
    import vproc_mem_responder_pkg::*;
#(
    parameter int          ADDR_BITS = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          RD_WAIT   = 0,
    parameter int          WR_WAIT   = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic        RD,
    input  logic [31:0] WrData,
    input  logic [11:0] Burst,
    input  logic        BurstFirst,
    input  logic        BurstLast,
    output logic [31:0] RdData,
    output logic        WRAck,
    output logic        RDAck,
    output logic        RangeErr,
    output logic        ProtoErr
);

    localparam logic [7:0] RD_W = 8'(RD_WAIT);
    localparam logic [7:0] WR_W = 8'(WR_WAIT);

    resp_state_t state_q;
    logic [7:0]  cnt_q;
    logic [31:0] addr_q, wdata_q;
    logic        wr_q, inrange_q, burst_q;
    logic [11:0] rem_q;
    logic        wrack_q, rdack_q, range_err_q, proto_err_q;

    logic                 idle, req, in_win, is_burst, enter_ack, cur_wr, cur_in;
    logic                 proto_hit, ram_we;
    logic [7:0]           wait_cnt;
    logic [11:0]          rem_eff;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [31:0]          ram_wdata, ram_rdata;

    always_comb begin
        idle      = (state_q == S_IDLE);
        req       = RD | WE;
        wait_cnt  = WE ? WR_W : RD_W;
        in_win    = in_window(Addr, BASE_ADDR, ADDR_BITS);
        is_burst  = (Burst > 12'd1);
        rem_eff   = BurstFirst ? Burst : rem_q;
        // In IDLE a zero-wait access commits on the sampling edge, so the RAM
        // must see the live bus rather than the latched copy.
        cur_wr    = idle ? WE : wr_q;
        cur_in    = idle ? in_win : inrange_q;
        ram_addr  = idle ? Addr[ADDR_BITS-1:0] : addr_q[ADDR_BITS-1:0];
        ram_wdata = idle ? WrData : wdata_q;
        enter_ack = (idle && req && (wait_cnt == 8'd0)) ||
                    ((state_q == S_WAIT) && (cnt_q == 8'd1));
        ram_we    = enter_ack && cur_wr && cur_in && !Reset;
        proto_hit = idle && req &&
                    ((RD && WE) ||
                     (is_burst && ((!BurstFirst && ((rem_q == 12'd0) || (Addr != addr_q + 32'd1))) ||
                                   (BurstLast && (rem_eff != 12'd1)))));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wr_q        <= 1'b0;
            inrange_q   <= 1'b0;
            burst_q     <= 1'b0;
            rem_q       <= 12'd0;
            wrack_q     <= 1'b0;
            rdack_q     <= 1'b0;
            range_err_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            wrack_q <= 1'b0;
            rdack_q <= 1'b0;
            if (proto_hit) proto_err_q <= 1'b1;
            if (idle && req && !in_win) range_err_q <= 1'b1;
            case (state_q)
                S_IDLE: if (req) begin
                    addr_q    <= Addr;
                    wdata_q   <= WrData;
                    wr_q      <= WE;
                    inrange_q <= in_win;
                    burst_q   <= is_burst;
                    if (is_burst) rem_q <= rem_eff;
                    cnt_q     <= wait_cnt;
                    state_q   <= (wait_cnt == 8'd0) ? S_ACK : S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_q <= S_ACK;
                end
                S_ACK: begin
                    // Bus values on this edge belong to the beat just acked.
                    state_q <= S_IDLE;
                    if (burst_q && (rem_q != 12'd0)) rem_q <= rem_q - 12'd1;
                end
                default: state_q <= S_IDLE;
            endcase
            if (enter_ack) begin
                wrack_q <= cur_wr;
                rdack_q <= !cur_wr;
            end
        end
    end

    vproc_resp_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk_i   (Clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign RdData   = (rdack_q && inrange_q) ? ram_rdata : OOR_RDATA;
    assign WRAck    = wrack_q;
    assign RDAck    = rdack_q;
    assign RangeErr = range_err_q;
    assign ProtoErr = proto_err_q;

endmodule
